// File: rtl/axi_lite_reg_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// AXI4-Lite DMA configuration register block.
package axi_lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] CTRL_OFS   = 32'h0;
  localparam logic [31:0] SRC_OFS    = 32'h4;
  localparam logic [31:0] DST_OFS    = 32'h8;
  localparam logic [31:0] LEN_OFS    = 32'hC;
  localparam logic [31:0] STATUS_OFS = 32'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  // Widest register the merge helper handles; callers cast in and out.
  localparam int MAX_W    = 64;
  localparam int MAX_STRB = MAX_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]    old,
                                                  input logic [MAX_W-1:0]    data,
                                                  input logic [MAX_STRB-1:0] strb);
    logic [MAX_W-1:0] res;
    res = old;
    for (int i = 0; i < MAX_STRB; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_interface.sv
// AXI4-Lite slave holding the DMA configuration registers (control, source,
// destination, length) plus read-only status fed from the DMA core.
module axi_lite_reg_interface
  import axi_lite_reg_pkg::*;
#(
  parameter int REG_WIDTH       = 32,
  parameter int WRITE_REG_COUNT = 4,
  parameter int READ_REG_COUNT  = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [31:0]            AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [REG_WIDTH-1:0]   WDATA,
  input  logic [REG_WIDTH/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [1:0]             BRESP,
  input  logic [31:0]            ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [REG_WIDTH-1:0]   RDATA,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [1:0]             RRESP,
  output logic                   start,
  output logic                   irq_enable,
  input  logic                   busy,
  input  logic                   done,
  output logic [REG_WIDTH-1:0]   src_addr,
  output logic [REG_WIDTH-1:0]   dst_addr,
  output logic [REG_WIDTH-1:0]   length
);

  localparam int STRB_W   = REG_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = 32 - ADDR_LSB;
  localparam int WSEL_W   = (WRITE_REG_COUNT > 1) ? $clog2(WRITE_REG_COUNT) : 1;

  localparam logic [IDX_W-1:0]  WR_CNT   = IDX_W'(WRITE_REG_COUNT);
  localparam logic [IDX_W-1:0]  ALL_CNT  = IDX_W'(WRITE_REG_COUNT + READ_REG_COUNT);
  localparam logic [IDX_W-1:0]  CTRL_IDX = IDX_W'(CTRL_OFS >> ADDR_LSB);
  localparam logic [WSEL_W-1:0] CTRL_SEL = WSEL_W'(CTRL_OFS >> ADDR_LSB);
  localparam logic [WSEL_W-1:0] SRC_SEL  = WSEL_W'(SRC_OFS >> ADDR_LSB);
  localparam logic [WSEL_W-1:0] DST_SEL  = WSEL_W'(DST_OFS >> ADDR_LSB);
  localparam logic [WSEL_W-1:0] LEN_SEL  = WSEL_W'(LEN_OFS >> ADDR_LSB);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [REG_WIDTH-1:0] regs [WRITE_REG_COUNT];
  logic [IDX_W-1:0]     aw_idx;
  logic [IDX_W-1:0]     ar_idx;
  logic                 aw_hs, w_hs, ar_hs;
  logic [REG_WIDTH-1:0] rd_data;
  logic [1:0]           rd_resp;
  logic                 unused_addr_bits;

  assign ar_idx = ARADDR[31:ADDR_LSB];
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;

  // Byte-offset bits below the register stride carry no information.
  assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  assign irq_enable = regs[CTRL_SEL][CTRL_IRQ_EN];
  assign src_addr   = regs[SRC_SEL];
  assign dst_addr   = regs[DST_SEL];
  assign length     = regs[LEN_SEL];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Ready/valid are forced low during reset so no handshake can complete.
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = !ARESET;
        if (AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = !ARESET;
        if (WVALID) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = !ARESET;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = !ARESET;
        if (RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    if (ar_idx < WR_CNT) begin
      rd_resp = RESP_OKAY;
      for (int i = 0; i < WRITE_REG_COUNT; i++) begin
        if (ar_idx == IDX_W'(i)) rd_data = regs[WSEL_W'(i)];
      end
    end else if (ar_idx < ALL_CNT) begin
      rd_resp = RESP_OKAY;
      if (ar_idx == WR_CNT) begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done;
      end
    end
  end

  // Start is a write-1-to-pulse bit: it never stores, it only fires for a cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < WRITE_REG_COUNT; i++) regs[WSEL_W'(i)] <= '0;
      aw_idx <= '0;
      start  <= 1'b0;
      BRESP  <= RESP_OKAY;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else begin
      start <= 1'b0;
      if (aw_hs) aw_idx <= AWADDR[31:ADDR_LSB];
      if (w_hs) begin
        BRESP <= (aw_idx < WR_CNT) ? RESP_OKAY : RESP_DECERR;
        for (int i = 0; i < WRITE_REG_COUNT; i++) begin
          if (aw_idx == IDX_W'(i))
            regs[WSEL_W'(i)] <= REG_WIDTH'(strb_merge(MAX_W'(regs[WSEL_W'(i)]),
                                                      MAX_W'(WDATA), MAX_STRB'(WSTRB)));
        end
        if (aw_idx == CTRL_IDX) begin
          regs[CTRL_SEL][CTRL_START] <= 1'b0;
          start <= WSTRB[0] && WDATA[CTRL_START];
        end
      end
      if (ar_hs) begin
        RDATA <= rd_data;
        RRESP <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_interface.sv
// Scoreboard bench for axi_lite_reg_interface: drivers push expectations from a
// behavioural register model, negedge monitors pop and compare on handshakes.
module tb_axi_lite_reg_interface;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;
  logic        start;
  logic        irq_enable;
  logic        busy;
  logic        done;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;

  axi_lite_reg_interface #(.REG_WIDTH(32), .WRITE_REG_COUNT(4), .READ_REG_COUNT(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
    .start(start), .irq_enable(irq_enable), .busy(busy), .done(done),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  resp;
    logic        irq;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  b_exp_t bq [$];
  r_exp_t rq [$];
  logic   sq [$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: four plain R/W words; status synthesized on read.
  logic [31:0] m [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output logic st);
    int idx;
    idx = int'(addr >> 2);
    st = 1'b0;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m[idx][8*b +: 8] = data[8*b +: 8];
      if (idx == 0) begin
        st = strb[0] & data[0];
        m[0][0] = 1'b0;
      end
      resp = 2'b00;
    end else begin
      resp = 2'b11;
    end
  endfunction

  function automatic r_exp_t model_read(input logic [31:0] addr, input logic b, input logic d);
    r_exp_t e;
    int idx;
    idx = int'(addr >> 2);
    e.data = 32'h0;
    e.resp = 2'b00;
    if (idx < 4)       e.data = m[idx];
    else if (idx == 4) e.data = {30'h0, d, b};
    else               e.resp = 2'b11;
    return e;
  endfunction

  task automatic wait_ready(input int which, input string nm);
    int n;
    logic r;
    n = 0;
    r = 1'b0;
    while (!r && n <= 200) begin
      @(negedge ACLK);
      case (which)
        0:       r = AWREADY;
        1:       r = WREADY;
        default: r = ARREADY;
      endcase
      n++;
    end
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: waited %0d cycles, expected ready", nm, n);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_valid(input int which, input string nm);
    int n;
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n <= 200) begin
      @(negedge ACLK);
      v = (which == 0) ? BVALID : RVALID;
      n++;
    end
    if (!v) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: waited %0d cycles, expected valid", nm, n);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] resp;
    logic       st;
    b_exp_t     e;
    model_write(addr, data, strb, resp, st);
    e = '{resp, m[0][1], m[1], m[2], m[3]};
    bq.push_back(e);
    sq.push_back(st);
    repeat (aw_dly) @(posedge ACLK);
    #1;
    AWADDR = addr;
    AWVALID = 1'b1;
    wait_ready(0, "awready");
    AWVALID = 1'b0;
    repeat (w_dly) @(posedge ACLK);
    #1;
    WDATA = data;
    WSTRB = strb;
    WVALID = 1'b1;
    wait_ready(1, "wready");
    WVALID = 1'b0;
    wait_valid(0, "bvalid");
    repeat (b_dly) @(posedge ACLK);
    @(posedge ACLK);
    #1 BREADY = 1'b1;
    @(posedge ACLK);
    #1 BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly, input logic b, input logic d);
    busy = b;
    done = d;
    rq.push_back(model_read(addr, b, d));
    ARADDR = addr;
    ARVALID = 1'b1;
    wait_ready(2, "arready");
    ARVALID = 1'b0;
    wait_valid(1, "rvalid");
    repeat (r_dly) @(posedge ACLK);
    @(posedge ACLK);
    #1 RREADY = 1'b1;
    @(posedge ACLK);
    #1 RREADY = 1'b0;
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_start", start, 0);
    chk("rst_irq_enable", irq_enable, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_length", length, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    for (int i = 0; i < 4; i++) m[i] = 32'h0;
    ARESET = 1'b0;
  endtask

  // B channel monitor: stability while stalled, response and outputs on handshake.
  b_exp_t      be;
  logic        b_hold = 1'b0;
  logic [1:0]  b_hold_resp;
  always @(negedge ACLK) begin
    if (BVALID) begin
      if (b_hold) chk("bresp_stable", BRESP, b_hold_resp);
      if (BREADY) begin
        if (bq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL b_unexpected: got BVALID with BRESP %0d, expected no response", BRESP);
        end else begin
          be = bq.pop_front();
          chk("bresp", BRESP, be.resp);
          chk("irq_enable", irq_enable, be.irq);
          chk("src_addr", src_addr, be.src);
          chk("dst_addr", dst_addr, be.dst);
          chk("length", length, be.len);
        end
        b_hold = 1'b0;
      end else begin
        b_hold = 1'b1;
        b_hold_resp = BRESP;
      end
    end else begin
      if (b_hold && !ARESET) chk("bvalid_held", BVALID, 1);
      b_hold = 1'b0;
    end
  end

  // R channel monitor.
  r_exp_t      re;
  logic        r_hold = 1'b0;
  logic [31:0] r_hold_data;
  logic [1:0]  r_hold_resp;
  always @(negedge ACLK) begin
    if (RVALID) begin
      if (r_hold) begin
        chk("rdata_stable", RDATA, r_hold_data);
        chk("rresp_stable", RRESP, r_hold_resp);
      end
      if (RREADY) begin
        if (rq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL r_unexpected: got RVALID with RDATA 0x%08h, expected no data", RDATA);
        end else begin
          re = rq.pop_front();
          chk("rdata", RDATA, re.data);
          chk("rresp", RRESP, re.resp);
        end
        r_hold = 1'b0;
      end else begin
        r_hold = 1'b1;
        r_hold_data = RDATA;
        r_hold_resp = RRESP;
      end
    end else begin
      if (r_hold && !ARESET) chk("rvalid_held", RVALID, 1);
      r_hold = 1'b0;
    end
  end

  // Start monitor: the cycle after each data handshake must match the model.
  logic s_pend = 1'b0;
  logic s_exp;
  always @(negedge ACLK) begin
    if (s_pend) begin
      chk("start", start, s_exp);
      s_pend = 1'b0;
    end else if (start) begin
      vectors++;
      miscompares++;
      $display("FAIL start_unexpected: got start=1, expected 0");
    end
    if (WVALID && WREADY) begin
      if (sq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL w_unexpected: got data handshake, expected none");
      end else begin
        s_exp = sq.pop_front();
        s_pend = 1'b1;
      end
    end
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    busy = 1'b0; done = 1'b0;
    @(posedge ACLK);
    apply_reset();

    do_write(32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h0, 0, 1'b0, 1'b0);

    apply_reset();
    do_write(32'h4, 32'h12345678, 4'h7, 0, 0, 0);
    do_read(32'h4, 0, 1'b0, 1'b0);

    do_write(32'h8, 32'hCAFEBABE, 4'hF, 0, 8, 1);
    do_write(32'hC, 32'hBAADF00D, 4'hF, 0, 1, 3);
    do_read(32'h8, 0, 1'b0, 1'b0);
    do_read(32'hC, 0, 1'b0, 1'b0);

    do_write(32'h10, 32'hDEADC0DE, 4'hF, 0, 0, 0);
    do_read(32'h10, 0, 1'b1, 1'b0);
    do_read(32'h20, 5, 1'b0, 1'b0);

    do_write(32'h0, 32'h0000_0006, 4'h1, 0, 0, 0);
    AWADDR = 32'h8;
    AWVALID = 1'b1;
    wait_ready(0, "awready_abort");
    AWVALID = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      chk("bvalid_after_abort", BVALID, 0);
    end
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 5; i++) do_read(32'(i * 4), 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge ACLK);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_interface.md
Name: axi_lite_reg_interface

Overview:
AXI4-Lite slave register block that fronts a DMA engine. It holds a bank of software-writable configuration registers: control, source address, destination address and length. It also exposes read-only status registers. It drives a start pulse and configuration outputs to the DMA core, and samples the core's busy/done flags.

Parameters:
REG_WIDTH, 32, data/register width in bits; the byte stride between registers is REG_WIDTH/8.
WRITE_REG_COUNT, 4, number of R/W registers, placed at offsets 0 .. (WRITE_REG_COUNT-1)*stride.
READ_REG_COUNT, 1, number of read-only registers, placed immediately after the R/W registers.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
AWADDR  in  32  write address
AWVALID/AWREADY  in/out  1  write-address handshake
WDATA  in  REG_WIDTH  write data
WSTRB  in  REG_WIDTH/8  byte strobes
WVALID/WREADY  in/out  1  write-data handshake
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARADDR  in  32  read address
ARVALID/ARREADY  in/out  1  read-address handshake
RDATA  out  REG_WIDTH  read data
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RRESP  out  2  read response
start  out  1  one-cycle DMA start pulse
irq_enable  out  1  control reg bit1
busy  in  1  DMA busy (status bit0)
done  in  1  DMA done (status bit1)
src_addr  out  REG_WIDTH  reg at 0x4
dst_addr  out  REG_WIDTH  reg at 0x8
length  out  REG_WIDTH  reg at 0xC

Behaviour:
- Reset state: all registers 0; start, irq_enable, src_addr, dst_addr and length 0. AWREADY, WREADY, BVALID, ARREADY and RVALID are 0 while ARESET=1. BRESP, RRESP and RDATA are 0. Both FSMs go to IDLE.
- Address decode: index = addr[31:2] (stride 4 at REG_WIDTH=32); low 2 bits are ignored.
  - Index < WRITE_REG_COUNT: R/W register.
  - Index < WRITE_REG_COUNT+READ_REG_COUNT: read-only register.
  - Anything else is unmapped.
- Write FSM, states W_IDLE → W_DATA → W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY at a clock edge, latch AWADDR and go to W_DATA.
  - W_DATA: WREADY=1. On WVALID&WREADY, perform the write (WDATA and WSTRB sampled at that edge), set BRESP and go to W_RESP.
  - W_RESP: BVALID=1, BRESP held stable. On BVALID&BREADY, return to W_IDLE.
  - WVALID asserted while in W_IDLE is not accepted until the address has been taken.
- Write semantics: byte lane i of the target register updates only if WSTRB[i]=1; other bytes keep their value. BRESP=2'b00 (OKAY) for a R/W target. Read-only or unmapped targets: no state change, BRESP=2'b11 (DECERR).
- Control reg (0x0):
  - bit0 is write-1-to-pulse. A write with byte0 strobed and WDATA[0]=1 drives start=1 for exactly the cycle after the data handshake. bit0 always stores and reads 0.
  - bit1 = irq_enable. Bits [REG_WIDTH-1:2] are plain storage.
- Status reg (first read-only reg): bit0=busy and bit1=done, sampled at read acceptance; other bits 0. Additional read-only regs read 0.
- Read FSM, states R_IDLE → R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, register RDATA/RRESP from ARADDR and go to R_DATA.
  - R_DATA: RVALID=1, RDATA/RRESP held until RVALID&RREADY, then return to R_IDLE.
  - Mapped address: RRESP=2'b00. Unmapped: RRESP=2'b11, RDATA=0.
- Read and write channels are independent. If a write commits in the same edge a read is accepted, the read returns the pre-write value.
- Reset asserted mid-transaction aborts it: FSMs go to IDLE, valids drop next cycle, registers clear.

Decomposition:
- Package axi_lite_reg_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11.
  - Offsets CTRL_OFS=0x0, SRC_OFS=0x4, DST_OFS=0x8, LEN_OFS=0xC, STATUS_OFS=0x10.
  - Control bit indices CTRL_START=0, CTRL_IRQ_EN=1.
  - Status bit indices STAT_BUSY=0, STAT_DONE=1.
  - Write and read FSM state enums.
  - Function strb_merge(old, data, strb).
- No sub-module; a single module is natural.

Test Plan:
- Write 0x0 = 0xDEADBEEF, WSTRB 0xF → BRESP 00; start pulses one cycle; irq_enable=1; read 0x0 = 0xDEADBEEE, RRESP 00.
- Write 0x4 = 0x12345678, WSTRB 0x7 (after reset) → BRESP 00; read 0x4 = 0x00345678; src_addr=0x00345678.
- Write 0x8 = 0xCAFEBABE with WVALID delayed 8 cycles and BREADY delayed 1 cycle, then 0xC = 0xBAADF00D with WVALID delay 1 and BREADY delay 3 → BRESP 00 each, BVALID held until BREADY; readback exact; dst_addr and length match.
- Write 0x10 = 0xDEADC0DE → BRESP 11, no register changed. With busy=1 and done=0, read 0x10 = 0x00000001, RRESP 00.
- Read 0x20 → RRESP 11, RDATA 0. Delaying RREADY by 5 cycles keeps RVALID, RDATA and RRESP stable.
- Assert ARESET mid-write (after AW handshake) → BVALID never asserts; all registers read 0 afterwards.
